// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types and constants for the RV32I ALU issue stage:
//            aluop encoding, opcode/funct constants, and the issue record
//            that travels from the decoder into the skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int SRCWIDTH   = 32;
  localparam int ALUOPWIDTH = 4;

  typedef enum logic [ALUOPWIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_AND  = 4'd8,
    ALU_SRA  = 4'd9
  } aluop_t;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Arithmetic funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    aluop_t                aluop;
    logic [SRCWIDTH-1:0]   src1;
    logic [SRCWIDTH-1:0]   src2;
    logic [SRCWIDTH-1:0]   imm;
    logic                  illegal;
  } issue_t;

  // Arithmetic funct3 to aluop; alt selects SUB/SRA over ADD/SRL.
  function automatic aluop_t f3_to_aluop(input logic [2:0] f3, input logic alt);
    aluop_t op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage_if
// Purpose  : Handshake bundle for the ALU issue stage.
//            Input side : in_valid/in_ready + inst, pc, rs1/rs2 data.
//            Output side: out_valid/out_ready + aluop, src1, src2, imm,
//                         illegal.
//            slave  modport: the issue stage.
//            master modport: the upstream/downstream environment.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if #(
  parameter int SRCWIDTH   = 32,
  parameter int ALUOPWIDTH = 4
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic [31:0]           in_pc;
  logic [SRCWIDTH-1:0]   in_rs1_data;
  logic [SRCWIDTH-1:0]   in_rs2_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ALUOPWIDTH-1:0] out_aluop;
  logic [SRCWIDTH-1:0]   out_src1;
  logic [SRCWIDTH-1:0]   out_src2;
  logic [SRCWIDTH-1:0]   out_imm;
  logic                  out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_aluop, out_src1, out_src2, out_imm,
           out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_aluop, out_src1, out_src2, out_imm,
           out_illegal
  );

endinterface
`default_nettype wire

// File: rtl/alu_inst_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_inst_decode
// Purpose  : Combinational RV32I decoder producing the ALU issue record.
// Ports    : inst  - instruction word
//            pc    - instruction PC
//            rs1   - rs1 register value
//            rs2   - rs2 register value
//            issue - {aluop, src1, src2, imm, illegal}
// Revision : 1.0 - initial release
// ============================================================================
module alu_inst_decode
  import alu_pkg::*;
(
  input  logic [31:0]         inst,
  input  logic [31:0]         pc,
  input  logic [SRCWIDTH-1:0] rs1,
  input  logic [SRCWIDTH-1:0] rs2,
  output issue_t              issue
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] shamt;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign i_imm  = {{20{inst[31]}}, inst[31:20]};
  assign s_imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm  = {inst[31:12], 12'b0};
  assign shamt  = {27'b0, inst[24:20]};

  aluop_t      op;
  logic [31:0] s1;
  logic [31:0] s2;
  logic [31:0] imm_v;
  logic        ill;

  always_comb begin
    op    = ALU_ADD;
    s1    = '0;
    s2    = '0;
    imm_v = '0;
    ill   = 1'b0;
    case (opcode)
      OPC_OP: begin
        s1  = rs1;
        s2  = rs2;
        op  = f3_to_aluop(f3, f7 == F7_ALT);
        // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
        ill = !((f7 == F7_BASE) ||
                (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)));
      end
      OPC_OPIMM: begin
        s1 = rs1;
        s2 = i_imm;
        // inst[31:25] is part of the immediate except for shifts.
        op = f3_to_aluop(f3, (f3 == F3_SRL_SRA) && (f7 == F7_ALT));
        if (f3 == F3_SLL) begin
          s2  = shamt;
          ill = (f7 != F7_BASE);
        end else if (f3 == F3_SRL_SRA) begin
          s2  = shamt;
          ill = !(f7 == F7_BASE || f7 == F7_ALT);
        end
      end
      OPC_LUI: begin
        s2 = u_imm;
      end
      OPC_AUIPC: begin
        s1 = pc;
        s2 = u_imm;
      end
      OPC_LOAD, OPC_JALR: begin
        s1 = rs1;
        s2 = i_imm;
      end
      OPC_STORE: begin
        s1    = rs1;
        s2    = s_imm;
        imm_v = s_imm;
      end
      OPC_JAL: begin
        s1 = pc;
        s2 = 32'd4;
      end
      OPC_BRANCH: begin
        s1    = rs1;
        s2    = rs2;
        imm_v = b_imm;
        case (f3)
          F3_BEQ, F3_BNE:   op = ALU_SUB;
          F3_BLT, F3_BGE:   op = ALU_SLT;
          F3_BLTU, F3_BGEU: op = ALU_SLTU;
          default:          ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    // Illegal encodings still issue, but with a clean all-zero payload.
    if (ill) begin
      op    = ALU_ADD;
      s1    = '0;
      s2    = '0;
      imm_v = '0;
    end
  end

  assign issue = '{aluop: op, src1: s1, src2: s2, imm: imm_v, illegal: ill};

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Decode/issue end of the RV32I ALU path. Decodes accepted
//            instructions and presents them registered to execute through
//            a 2-entry skid buffer with a registered in_ready and flush.
// Ports    : clk   - core clock
//            rst_n - asynchronous active-low reset
//            flush - drop buffered and incoming instructions
//            bus   - alu_issue_stage_if.slave (in_* handshake in,
//                    out_* handshake out)
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  alu_issue_stage_if.slave    bus
);

  issue_t     dec;
  issue_t     entry0_q, entry0_d;
  issue_t     entry1_q, entry1_d;
  logic [1:0] count_q, count_d;
  logic       ready_q, ready_d;
  logic       accept;
  logic       handshake;

  alu_inst_decode u_decode (
    .inst  (bus.in_inst),
    .pc    (bus.in_pc),
    .rs1   (bus.in_rs1_data),
    .rs2   (bus.in_rs2_data),
    .issue (dec)
  );

  assign accept    = bus.in_valid & ready_q & ~flush;
  assign handshake = (count_q != 2'd0) & bus.out_ready;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (accept) begin
            entry0_d = dec;
            count_d  = 2'd1;
          end
        end
        2'd1: begin
          if (handshake && accept) begin
            entry0_d = dec;
          end else if (handshake) begin
            count_d = 2'd0;
          end else if (accept) begin
            entry1_d = dec;
            count_d  = 2'd2;
          end
        end
        default: begin
          // Full: in_ready was low, so no accept can land here.
          if (handshake) begin
            entry0_d = entry1_q;
            count_d  = 2'd1;
          end
        end
      endcase
    end
    // Registered ready looks only at next occupancy, never at out_ready.
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
      ready_q  <= 1'b1;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.out_aluop   = entry0_q.aluop;
  assign bus.out_src1    = entry0_q.src1;
  assign bus.out_src2    = entry0_q.src2;
  assign bus.out_imm     = entry0_q.imm;
  assign bus.out_illegal = entry0_q.illegal;

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue end of the ALU interface in the RV32I core.
- Accepts a fetched instruction plus register-file operands through a valid/ready handshake, decodes them into an aluop and two 32-bit sources, and presents them registered to the execute stage.
- A 2-entry skid buffer gives full throughput with a registered in_ready; flush supports branch/jump redirects.

Parameters:
- SRCWIDTH, 32, operand/result width (fixed at 32 for RV32I).
- ALUOPWIDTH, 4, width of aluop encoding.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  drop all buffered and incoming instructions.
- in_valid  input  1  instruction/operands valid.
- in_ready  output  1  stage can accept (registered).
- in_inst  input  32  instruction word.
- in_pc  input  32  instruction PC.
- in_rs1_data  input  SRCWIDTH  rs1 register value.
- in_rs2_data  input  SRCWIDTH  rs2 register value.
- out_valid  output  1  issued op valid.
- out_ready  input  1  execute stage accepts.
- out_aluop  output  ALUOPWIDTH  aluop_t.
- out_src1  output  SRCWIDTH  ALU source 1.
- out_src2  output  SRCWIDTH  ALU source 2.
- out_imm  output  SRCWIDTH  sign-extended immediate (branch/store offset).
- out_illegal  output  1  unsupported encoding.

Behaviour:
- aluop encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, OR=7, AND=8, SRA=9; 10–15 are never driven.
- Reset (async, rst_n=0): out_valid=0, in_ready=1, all data outputs 0, both buffer entries empty.
- Decode (combinational, captured on accept = in_valid & in_ready & !flush):
  - OP (0110011): funct3/funct7 give ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; src1=rs1, src2=rs2.
  - OP-IMM (0010011): same, src2=I-imm.
    - SLLI/SRLI need funct7=0000000; SRAI needs funct7=0100000; otherwise illegal.
    - src2 for shifts = zero-extended shamt.
  - LUI: ADD, src1=0, src2=U-imm. AUIPC: ADD, src1=pc, src2=U-imm.
  - LOAD/JALR: ADD, src1=rs1, src2=I-imm. STORE: ADD, src1=rs1, src2=S-imm, out_imm=S-imm.
  - JAL: ADD, src1=pc, src2=4.
  - BRANCH: src1=rs1, src2=rs2, out_imm=B-imm.
    - BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
    - funct3 010/011 is illegal.
  - Any other opcode or illegal funct: aluop=ADD, src1=src2=imm=0, illegal=1. The entry still issues; the downstream trap handler consumes it.
- Latency: 1 cycle from accept to out_valid when the buffer is empty; in order, no loss, no duplication.
- Skid buffer:
  - Entry 0 drives the outputs; entry 1 catches the accept that occurs while entry 0 is stalled.
  - in_ready(next) = !(both entries occupied after this cycle); it never depends combinationally on out_ready.
  - Simultaneous accept and out-handshake with 1 entry: entry 0 is replaced, count stays 1.
  - Out-handshake with 2 entries: entry 1 moves to entry 0.
- Flush:
  - Next cycle: out_valid=0, both entries empty, in_ready=1.
  - An instruction presented in the flush cycle is not accepted.
  - Flush has priority over every accept and handshake in the same cycle.
- Output data is held stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation clears everything immediately; there is no partial state.

Decomposition:
- Package alu_pkg: aluop_t enum (the encoding above), opcode constants (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR), funct3/funct7 constants, and a packed issue_t struct {aluop, src1, src2, imm, illegal}.
- One combinational sub-module, alu_inst_decode (inst, pc, rs1, rs2 -> issue_t). The top holds the skid buffer and flush control.

Test Plan:
- 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, aluop=0, src1=5, src2=7, illegal=0.
- 0xFFF00093 (addi x1,x0,-1), rs1=0 -> aluop=0, src2=0xFFFFFFFF. Then 0x4040D093 (srai x1,x1,4) -> aluop=9, src2=4. Then 0x123450B7 (lui) -> aluop=0, src1=0, src2=0x12345000.
- 0x0020E463 (bltu x1,x2,+8), rs1=3, rs2=0xFFFFFFFF -> aluop=4, src1=3, src2=0xFFFFFFFF, imm=8. Then 0x0000007F -> illegal=1, aluop=0, srcs=0.
- out_ready=0, three back-to-back valid adds -> two accepted, in_ready=0 on the third cycle. Release out_ready -> three ops issue in order with no gap, and in_ready returns to 1.
- Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed and incoming ops never appear.
- rst_n pulsed low mid-stall for a fraction of a cycle -> outputs 0 and out_valid=0 immediately (asynchronously); operation resumes normally after release.
